// File: rtl/jt12_exp_arb_if.sv
// Requester-side bus of the exponent ROM arbiter.
// master: requester side (drives req/addr_in, receives grants and results).
// slave : arbiter side.
interface jt12_exp_arb_if #(
    parameter int N      = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 10
);
    logic [N-1:0]        req;
    logic [N*ADDR_W-1:0] addr_in;
    logic [N-1:0]        gnt;
    logic [N-1:0]        rsp_valid;
    logic [DATA_W-1:0]   rsp_data;

    modport master (
        output req, addr_in,
        input  gnt, rsp_valid, rsp_data
    );

    modport slave (
        input  req, addr_in,
        output gnt, rsp_valid, rsp_data
    );
endinterface

// File: rtl/jt12_exp_arb.sv
// Arbiter sharing one jt12_exprom lookup port between N requesters.
// Select -> ROM read -> response, a fixed 3-stage shift with no stalls.
// Results return tagged with a one-hot rsp_valid to the issuing requester.
// Build option: JT12_EXP_ARB_FIXPRIO_EN selects fixed priority (lowest index
// wins, no rotation pointer); undefined gives round-robin.
module jt12_exp_arb #(
    parameter int N      = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    jt12_exp_arb_if.slave     bus,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);
    localparam int IDX_W = $clog2(N);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0]     elig;
    logic             found;
    logic [IDX_W-1:0] win;
    int               idx;

    logic             s1_vld, s2_vld;
    logic [IDX_W-1:0] s1_id, s2_id;

`ifndef JT12_EXP_ARB_FIXPRIO_EN
    logic [IDX_W-1:0] last;
`endif

    // A requester whose grant is still visible is not yet done holding req.
    assign elig = bus.req & ~bus.gnt;

    // Winner search: first eligible requester after the last winner (or from 0).
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
`ifdef JT12_EXP_ARB_FIXPRIO_EN
            idx = k;
`else
            idx = int'(last) + 1 + k;
            if (idx >= N) idx = idx - N;
`endif
            if (!found && elig[IDX_W'(idx)]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    // Select stage: issue grant and ROM address, open a pipeline slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.gnt  <= '0;
            rom_addr <= '0;
            s1_vld   <= 1'b0;
            s1_id    <= '0;
`ifndef JT12_EXP_ARB_FIXPRIO_EN
            last     <= IDX_W'(N-1);
`endif
        end else if (clk_en) begin
            if (found) begin
                bus.gnt  <= ONE << win;
                rom_addr <= bus.addr_in[int'(win)*ADDR_W +: ADDR_W];
                s1_vld   <= 1'b1;
                s1_id    <= win;
`ifndef JT12_EXP_ARB_FIXPRIO_EN
                last     <= win;
`endif
            end else begin
                bus.gnt <= '0;
                s1_vld  <= 1'b0;
            end
        end
    end

    // ROM read stage: the ROM registers its output while the tag follows along.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            s2_id  <= '0;
        end else if (clk_en) begin
            s2_vld <= s1_vld;
            s2_id  <= s1_id;
        end
    end

    // Response stage: capture ROM data and steer the one-hot valid to its owner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
        end else if (clk_en) begin
            bus.rsp_valid <= s2_vld ? (ONE << s2_id) : '0;
            if (s2_vld) bus.rsp_data <= rom_data;
        end
    end
endmodule
